win_scanner: RTL and testbench



---
 rtl/win_scanner.sv | 230 +++++++++++++++++++++++
 tb/tb_win_scanner.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_scanner.sv
// ---------------------------------------------------------------------------
// win_scanner
//
// Sequential win detector for a Connect-Four style board of ROWS x COLS cells.
// A start pulse snapshots the red and yellow occupancy vectors, then one
// anchor cell is examined per clock in ascending index order. For every
// anchor, four line directions are tested for both colours. At the end of
// the walk the block pulses done and presents the winner flags, the first
// winning line found, the board-full draw flag and the overlap flag.
//
// Cell (r,c) lives at bit r*COLS+c. Row 0 is the top row, col 0 the leftmost.
//
// Ports
//   clk        in   1   clock
//   resetn     in   1   synchronous active-low reset
//   start      in   1   scan request, accepted only while busy=0
//   red        in   N   red occupancy, sampled on an accepted start
//   yellow     in   N   yellow occupancy, sampled on an accepted start
//   busy       out  1   scan in progress
//   done       out  1   one-cycle pulse, results valid
//   red_win    out  1   red owns at least one winning line
//   yellow_win out  1   yellow owns at least one winning line
//   draw       out  1   board full and nobody won
//   illegal    out  1   some cell is set in both vectors
//   win_row    out  RW  anchor row of the reported line
//   win_col    out  CW  anchor column of the reported line
//   win_dir    out  2   0 horizontal, 1 vertical, 2 down-right, 3 down-left
// ---------------------------------------------------------------------------
module win_scanner #(
  parameter  int ROWS    = 6,
  parameter  int COLS    = 7,
  parameter  int WIN_LEN = 4,
  localparam int N       = ROWS * COLS,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [N-1:0]  red,
  input  logic [N-1:0]  yellow,
  output logic          busy,
  output logic          done,
  output logic          red_win,
  output logic          yellow_win,
  output logic          draw,
  output logic          illegal,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [1:0]    win_dir
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } stateT;

  stateT         state;
  logic [N-1:0]  snapRed;
  logic [N-1:0]  snapYellow;
  logic [RW-1:0] rowIdx;
  logic [CW-1:0] colIdx;
  logic [3:0]    redHit;
  logic [3:0]    yellowHit;
  logic          anyHit;
  logic [1:0]    firstDir;
  logic          lastAnchor;
  logic          finalRedWin;
  logic          finalYellowWin;

  // The anchor index is kept as separate row and column counters so that no
  // divider is needed to recover (r,c). The last anchor is the bottom-right
  // cell.
  assign lastAnchor = (rowIdx == RW'(ROWS - 1)) && (colIdx == CW'(COLS - 1));

  // Evaluate all four directions of the current anchor for both colours.
  // A direction whose far end would leave the board is forced to miss before
  // any cell is looked at, which is also what stops a horizontal run from
  // wrapping into the next row. Only in-range cells are ever indexed.
  always_comb begin
    int   r;
    int   c;
    int   rr;
    int   cc;
    int   dRow;
    int   dCol;
    logic rowFits;
    logic rightFits;
    logic leftFits;
    logic inRange;
    logic allRed;
    logic allYellow;
    logic [IW-1:0] bitIdx;

    redHit    = '0;
    yellowHit = '0;
    r         = int'(rowIdx);
    c         = int'(colIdx);
    rr        = 0;
    cc        = 0;
    dRow      = 0;
    dCol      = 0;
    bitIdx    = '0;
    rowFits   = (r + WIN_LEN - 1) < ROWS;
    rightFits = (c + WIN_LEN - 1) < COLS;
    leftFits  = c >= (WIN_LEN - 1);

    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin inRange = rightFits;            dRow = 0; dCol = 1;  end
        1:       begin inRange = rowFits;              dRow = 1; dCol = 0;  end
        2:       begin inRange = rowFits && rightFits; dRow = 1; dCol = 1;  end
        default: begin inRange = rowFits && leftFits;  dRow = 1; dCol = -1; end
      endcase
      allRed    = inRange;
      allYellow = inRange;
      if (inRange) begin
        for (int k = 0; k < WIN_LEN; k++) begin
          rr        = r + dRow * k;
          cc        = c + dCol * k;
          bitIdx    = IW'(rr * COLS + cc);
          allRed    = allRed & snapRed[bitIdx];
          allYellow = allYellow & snapYellow[bitIdx];
        end
      end
      redHit[d]    = allRed;
      yellowHit[d] = allYellow;
    end
  end

  // Pick the direction to report for this anchor. Red outranks yellow and a
  // lower direction number outranks a higher one, so the loops run from the
  // weakest candidate to the strongest and the strongest assignment sticks.
  always_comb begin
    anyHit   = (|redHit) | (|yellowHit);
    firstDir = '0;
    for (int d = 3; d >= 0; d--) begin
      if (yellowHit[d]) firstDir = 2'(d);
    end
    for (int d = 3; d >= 0; d--) begin
      if (redHit[d]) firstDir = 2'(d);
    end
  end

  // Win flags including the anchor being evaluated this cycle, needed so the
  // draw decision on the last anchor sees hits from that anchor too.
  assign finalRedWin    = red_win | (|redHit);
  assign finalYellowWin = yellow_win | (|yellowHit);

  // Control FSM with all outputs registered. IDLE snapshots the board and
  // clears the previous results, SCAN walks one anchor per clock and
  // accumulates sticky win flags plus the first reported line, DONE holds the
  // done pulse for exactly one cycle and deliberately ignores start, so a
  // request made there is picked up in the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      snapRed    <= '0;
      snapYellow <= '0;
      rowIdx     <= '0;
      colIdx     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      red_win    <= 1'b0;
      yellow_win <= 1'b0;
      draw       <= 1'b0;
      illegal    <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_dir    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snapRed    <= red;
            snapYellow <= yellow;
            rowIdx     <= '0;
            colIdx     <= '0;
            busy       <= 1'b1;
            red_win    <= 1'b0;
            yellow_win <= 1'b0;
            draw       <= 1'b0;
            illegal    <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_dir    <= '0;
            state      <= SCAN;
          end
        end

        SCAN: begin
          if (|redHit)    red_win    <= 1'b1;
          if (|yellowHit) yellow_win <= 1'b1;
          // Nothing has been reported yet exactly when both flags are clear.
          if (anyHit && !red_win && !yellow_win) begin
            win_row <= rowIdx;
            win_col <= colIdx;
            win_dir <= firstDir;
          end
          if (lastAnchor) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            draw    <= (&(snapRed | snapYellow)) & !finalRedWin & !finalYellowWin;
            illegal <= |(snapRed & snapYellow);
            state   <= DONE;
          end else if (colIdx == CW'(COLS - 1)) begin
            colIdx <= '0;
            rowIdx <= rowIdx + 1'b1;
          end else begin
            colIdx <= colIdx + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// ---------------------------------------------------------------------------
// tb_win_scanner
//
// Bench for win_scanner. Two instances share clock and reset: the default
// 6x7 / 4-in-a-row board and a 4x4 / 3-in-a-row board. A board-level model
// computes the expected results straight from the game rules, a timing model
// tracks where the default instance should be in its scan, and a compare
// process checks that instance on every cycle. Directed tests add literal
// expectations on top.
// ---------------------------------------------------------------------------
module tb_win_scanner;

  localparam int ROWS_A = 6;
  localparam int COLS_A = 7;
  localparam int NA     = ROWS_A * COLS_A;
  localparam int ROWS_B = 4;
  localparam int COLS_B = 4;
  localparam int NB     = ROWS_B * COLS_B;

  typedef struct packed {
    int redWin;
    int yellowWin;
    int draw;
    int illegal;
    int row;
    int col;
    int dir;
  } scanRes;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [NA-1:0] red;
  logic [NA-1:0] yellow;
  logic          busy;
  logic          done;
  logic          red_win;
  logic          yellow_win;
  logic          draw;
  logic          illegal;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic [1:0]    win_dir;

  logic          startB;
  logic [NB-1:0] redB;
  logic [NB-1:0] yellowB;
  logic          busyB;
  logic          doneB;
  logic          redWinB;
  logic          yellowWinB;
  logic          drawB;
  logic          illegalB;
  logic [1:0]    winRowB;
  logic [1:0]    winColB;
  logic [1:0]    winDirB;

  int     checkCount = 0;
  int     passCount  = 0;
  int     phase      = 0;
  bit     armed      = 0;
  scanRes expRes     = '0;
  scanRes pendingRes = '0;

  win_scanner dutA (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .red        (red),
    .yellow     (yellow),
    .busy       (busy),
    .done       (done),
    .red_win    (red_win),
    .yellow_win (yellow_win),
    .draw       (draw),
    .illegal    (illegal),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_dir    (win_dir)
  );

  win_scanner #(.ROWS(ROWS_B), .COLS(COLS_B), .WIN_LEN(3)) dutB (
    .clk        (clk),
    .resetn     (resetn),
    .start      (startB),
    .red        (redB),
    .yellow     (yellowB),
    .busy       (busyB),
    .done       (doneB),
    .red_win    (redWinB),
    .yellow_win (yellowWinB),
    .draw       (drawB),
    .illegal    (illegalB),
    .win_row    (winRowB),
    .win_col    (winColB),
    .win_dir    (winDirB)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Game-rule model: try every anchor in order, red before yellow, directions
  // 0..3, and call a line a win when every one of its cells is on the board
  // and owned by that colour.
  function automatic scanRes modelScan(input logic [63:0] rb, input logic [63:0] yb,
                                       input int rows, input int cols, input int wl);
    scanRes      res;
    logic [63:0] board;
    int          dr;
    int          dc;
    int          rr;
    int          cc;
    bit          ok;
    bit          found;
    bit          full;
    bit          ill;
    res   = '0;
    found = 0;
    for (int idx = 0; idx < rows * cols; idx++) begin
      for (int colour = 0; colour < 2; colour++) begin
        board = (colour == 0) ? rb : yb;
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
          ok = 1;
          for (int k = 0; k < wl; k++) begin
            rr = idx / cols + dr * k;
            cc = idx % cols + dc * k;
            if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) ok = 0;
            else if (!board[rr * cols + cc]) ok = 0;
          end
          if (ok) begin
            if (colour == 0) res.redWin = 1;
            else res.yellowWin = 1;
            if (!found) begin
              found   = 1;
              res.row = idx / cols;
              res.col = idx % cols;
              res.dir = d;
            end
          end
        end
      end
    end
    full = 1;
    ill  = 0;
    for (int i = 0; i < rows * cols; i++) begin
      if (!(rb[i] | yb[i])) full = 0;
      if (rb[i] & yb[i]) ill = 1;
    end
    res.illegal = int'(ill);
    res.draw    = int'(full && res.redWin == 0 && res.yellowWin == 0);
    return res;
  endfunction

  // Timing model of the default instance. phase 0 is idle, 1..NA are the
  // busy cycles after an accepted start, NA+1 is the done cycle. Results
  // become visible in the done cycle and stay until the next accepted start.
  always @(posedge clk) begin
    if (!resetn) begin
      armed  = 1;
      phase  = 0;
      expRes = '0;
    end else if (phase == 0) begin
      if (start) begin
        pendingRes = modelScan(64'(red), 64'(yellow), ROWS_A, COLS_A, 4);
        expRes     = '0;
        phase      = 1;
      end
    end else if (phase == NA) begin
      phase  = NA + 1;
      expRes = pendingRes;
    end else if (phase == NA + 1) begin
      phase = 0;
    end else begin
      phase = phase + 1;
    end
  end

  // Cycle-by-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("busy", int'(busy), int'(phase >= 1 && phase <= NA));
      checkOutput("done", int'(done), int'(phase == NA + 1));
      if (phase == 0 || phase == NA + 1) begin
        checkOutput("red_win",    int'(red_win),    expRes.redWin);
        checkOutput("yellow_win", int'(yellow_win), expRes.yellowWin);
        checkOutput("draw",       int'(draw),       expRes.draw);
        checkOutput("illegal",    int'(illegal),    expRes.illegal);
        checkOutput("win_row",    int'(win_row),    expRes.row);
        checkOutput("win_col",    int'(win_col),    expRes.col);
        checkOutput("win_dir",    int'(win_dir),    expRes.dir);
      end
    end
  end

  // Launch one scan on the chosen instance and wait (bounded) for done.
  // latency is the cycle, counted from the cycle start was raised, in which
  // done shows up, or -1 if it never did. Optionally a stray start with a
  // scrambled board is injected mid-scan, and/or reset is pulsed mid-scan.
  task automatic applyStimulus(input bit useSmall, input logic [NA-1:0] r,
                               input logic [NA-1:0] y, input int pulseAt,
                               input int resetAt, output int latency);
    @(negedge clk);
    if (useSmall) begin
      redB    = r[NB-1:0];
      yellowB = y[NB-1:0];
      startB  = 1'b1;
    end else begin
      red    = r;
      yellow = y;
      start  = 1'b1;
    end
    latency = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (useSmall ? doneB : done) begin
        latency = cyc;
        break;
      end
      if (cyc == 1) begin
        start  = 1'b0;
        startB = 1'b0;
      end
      if (pulseAt > 0 && cyc == pulseAt) begin
        start = 1'b1;
        red   = '1;
      end
      if (pulseAt > 0 && cyc == pulseAt + 1) start = 1'b0;
      if (resetAt > 0 && cyc == resetAt) resetn = 1'b0;
      if (resetAt > 0 && cyc == resetAt + 2) resetn = 1'b1;
    end
    start  = 1'b0;
    startB = 1'b0;
  endtask

  initial begin
    logic [NA-1:0] rv;
    logic [NA-1:0] yv;
    scanRes        m;
    int            lat;

    red     = '0;
    yellow  = '0;
    redB    = '0;
    yellowB = '0;
    startB  = 1'b0;
    start   = 1'b1;
    resetn  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset with start held high");
    checkOutput("reset_busy",    int'(busy),    0);
    checkOutput("reset_done",    int'(done),    0);
    checkOutput("reset_red_win", int'(red_win), 0);
    checkOutput("reset_win_row", int'(win_row), 0);
    checkOutput("reset_busyB",   int'(busyB),   0);
    start  = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] red horizontal win on the bottom row");
    rv = '0; yv = '0;
    rv[38] = 1'b1; rv[39] = 1'b1; rv[40] = 1'b1; rv[41] = 1'b1;
    m = modelScan(64'(rv), 64'(yv), ROWS_A, COLS_A, 4);
    checkOutput("model_t1_row", m.row, 5);
    checkOutput("model_t1_col", m.col, 3);
    applyStimulus(1'b0, rv, yv, 0, 0, lat);
    checkOutput("t1_latency",    lat,              43);
    checkOutput("t1_red_win",    int'(red_win),    1);
    checkOutput("t1_yellow_win", int'(yellow_win), 0);
    checkOutput("t1_win_row",    int'(win_row),    5);
    checkOutput("t1_win_col",    int'(win_col),    3);
    checkOutput("t1_win_dir",    int'(win_dir),    0);
    checkOutput("t1_draw",       int'(draw),       0);
    repeat (2) @(negedge clk);

    $display("[TB] yellow down-left win");
    rv = '0; yv = '0;
    yv[6] = 1'b1; yv[12] = 1'b1; yv[18] = 1'b1; yv[24] = 1'b1;
    rv[0] = 1'b1; rv[7] = 1'b1;
    m = modelScan(64'(rv), 64'(yv), ROWS_A, COLS_A, 4);
    checkOutput("model_t2_dir", m.dir, 3);
    applyStimulus(1'b0, rv, yv, 0, 0, lat);
    checkOutput("t2_latency",    lat,              43);
    checkOutput("t2_red_win",    int'(red_win),    0);
    checkOutput("t2_yellow_win", int'(yellow_win), 1);
    checkOutput("t2_win_row",    int'(win_row),    0);
    checkOutput("t2_win_col",    int'(win_col),    6);
    checkOutput("t2_win_dir",    int'(win_dir),    3);
    repeat (2) @(negedge clk);

    $display("[TB] horizontal run across a row edge");
    rv = '0; yv = '0;
    rv[5] = 1'b1; rv[6] = 1'b1; rv[7] = 1'b1; rv[8] = 1'b1;
    applyStimulus(1'b0, rv, yv, 0, 0, lat);
    checkOutput("t3_red_win", int'(red_win), 0);
    checkOutput("t3_draw",    int'(draw),    0);
    checkOutput("t3_illegal", int'(illegal), 0);
    repeat (2) @(negedge clk);

    $display("[TB] full board without a winner, then with an overlap");
    rv = '0;
    for (int r = 0; r < ROWS_A; r++) begin
      for (int c = 0; c < COLS_A; c++) begin
        if ((((c >> 1) + r) % 2) == 0) rv[r * COLS_A + c] = 1'b1;
      end
    end
    yv = ~rv;
    m = modelScan(64'(rv), 64'(yv), ROWS_A, COLS_A, 4);
    checkOutput("model_t4_draw", m.draw, 1);
    applyStimulus(1'b0, rv, yv, 0, 0, lat);
    checkOutput("t4_draw",       int'(draw),       1);
    checkOutput("t4_red_win",    int'(red_win),    0);
    checkOutput("t4_yellow_win", int'(yellow_win), 0);
    checkOutput("t4_illegal",    int'(illegal),    0);
    rv[0] = 1'b1;
    yv[0] = 1'b1;
    applyStimulus(1'b0, rv, yv, 0, 0, lat);
    checkOutput("t5_illegal", int'(illegal), 1);
    checkOutput("t5_draw",    int'(draw),    1);
    repeat (2) @(negedge clk);

    $display("[TB] stray start and input change mid-scan");
    rv = '0; yv = '0;
    rv[38] = 1'b1; rv[39] = 1'b1; rv[40] = 1'b1; rv[41] = 1'b1;
    applyStimulus(1'b0, rv, yv, 10, 0, lat);
    checkOutput("t6_latency", lat,           43);
    checkOutput("t6_win_col", int'(win_col), 3);
    checkOutput("t6_illegal", int'(illegal), 0);
    repeat (2) @(negedge clk);

    $display("[TB] reset in the middle of a scan");
    applyStimulus(1'b0, rv, yv, 0, 20, lat);
    checkOutput("t7_no_done", lat,              -1);
    checkOutput("t7_busy",    int'(busy),       0);
    checkOutput("t7_red_win", int'(red_win),    0);
    checkOutput("t7_win_row", int'(win_row),    0);
    checkOutput("t7_win_col", int'(win_col),    0);
    repeat (2) @(negedge clk);

    $display("[TB] 4x4 board, three in a row, diagonal");
    rv = '0; yv = '0;
    rv[0] = 1'b1; rv[5] = 1'b1; rv[10] = 1'b1;
    m = modelScan(64'(rv), 64'(yv), ROWS_B, COLS_B, 3);
    applyStimulus(1'b1, rv, yv, 0, 0, lat);
    checkOutput("b_latency",    lat,              17);
    checkOutput("b_red_win",    int'(redWinB),    1);
    checkOutput("b_yellow_win", int'(yellowWinB), 0);
    checkOutput("b_win_dir",    int'(winDirB),    2);
    checkOutput("b_win_row",    int'(winRowB),    0);
    checkOutput("b_win_col",    int'(winColB),    0);
    checkOutput("b_model_dir",  int'(winDirB),    m.dir);
    checkOutput("b_model_draw", int'(drawB),      m.draw);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
